// File: rtl/d_ff_pkg.sv
// ---------------------------------------------------------------------------
// d_ff_pkg
//    Shared constants and helpers for the d_ff register / delay line.
//    Holds the legal parameter limits and the range-check function that the
//    top level uses to reject illegal configurations at elaboration time.
// ---------------------------------------------------------------------------
package d_ff_pkg;

   localparam int D_FF_MAX_WIDTH  = 64;
   localparam int D_FF_MAX_STAGES = 16;

   // Returns 1 when both width and stage count lie within their legal ranges.
   function automatic bit d_ff_param_ok(input int width, input int stages);
      return (width  >= 1) && (width  <= D_FF_MAX_WIDTH) &&
             (stages >= 1) && (stages <= D_FF_MAX_STAGES);
   endfunction

endpackage : d_ff_pkg

// File: rtl/d_ff_stage.sv
// ---------------------------------------------------------------------------
// d_ff_stage
//    One WIDTH-bit positive-edge flop with a synchronous active-low reset
//    that loads RESET_VALUE. Building block of the d_ff delay line.
//
// Ports:
//    clk  in   1      clock, rising edge active
//    rst  in   1      synchronous reset, 0 = load RESET_VALUE, 1 = run
//    d    in   WIDTH  data input
//    q    out  WIDTH  registered data output
// ---------------------------------------------------------------------------
module d_ff_stage
   import d_ff_pkg::*;
#(
   parameter int               WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Reset is only looked at on the rising edge, so a pulse on rst that
   // starts and ends between edges leaves the stored value alone.
   always_ff @(posedge clk) begin
      if (!rst) begin
         q <= RESET_VALUE;
      end else begin
         q <= d;
      end
   end

endmodule : d_ff_stage

// File: rtl/d_ff.sv
// ---------------------------------------------------------------------------
// d_ff
//    Parameterizable D register. With the defaults it is a single 1-bit
//    flip-flop; with STAGES > 1 it becomes a STAGES-deep delay line where
//    data sampled at edge n appears on Q after edge n+STAGES-1.
//    Q comes straight from the last flop, so there is no combinational path
//    from D or RST to Q.
//
// Parameters:
//    WIDTH        data width, 1..64
//    STAGES       number of cascaded flops, 1..16
//    RESET_VALUE  value loaded into every stage while RST is low
//                 (truncated / zero-extended to WIDTH by its declared type)
//
// Ports:
//    CLK  in   1      clock, rising edge active
//    RST  in   1      synchronous active-low reset, 0 = reset, 1 = run
//    D    in   WIDTH  data input
//    Q    out  WIDTH  output of the last stage
// ---------------------------------------------------------------------------
module d_ff
   import d_ff_pkg::*;
#(
   parameter int               WIDTH       = 1,
   parameter int               STAGES      = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
);

   // Illegal configurations stop elaboration rather than silently building
   // a truncated or empty chain.
   if (!d_ff_param_ok(WIDTH, STAGES)) begin : g_bad_params
      $fatal(1, "d_ff: WIDTH=%0d (1..%0d) or STAGES=%0d (1..%0d) out of range",
             WIDTH, D_FF_MAX_WIDTH, STAGES, D_FF_MAX_STAGES);
   end

   logic [WIDTH-1:0] stage_q [STAGES];

   // Chain of identical stages: the first takes D, each later one takes its
   // predecessor. All share RST, so one low edge clears every stage at once
   // and any data still in flight is dropped.
   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      if (i == 0) begin : g_first
         d_ff_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
         ) u_stage (
            .clk (CLK),
            .rst (RST),
            .d   (D),
            .q   (stage_q[i])
         );
      end else begin : g_next
         d_ff_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
         ) u_stage (
            .clk (CLK),
            .rst (RST),
            .d   (stage_q[i-1]),
            .q   (stage_q[i])
         );
      end
   end

   assign Q = stage_q[STAGES-1];

endmodule : d_ff

// File: tb/tb_d_ff.sv
// ---------------------------------------------------------------------------
// tb_d_ff
//    Self-checking bench for d_ff. Two instances share one 20 ns clock:
//    dut_a uses the default 1-bit single-stage configuration, dut_b is an
//    8-bit, 3-stage delay line resetting to 8'hA5. Each is driven from a
//    table of per-cycle {rst, d, expected q} records, followed by short
//    hand-written sequences for between-edge glitches on D and RST.
// ---------------------------------------------------------------------------
module tb_d_ff;

   typedef struct packed {
      logic       rst;
      logic [7:0] d;
      logic [7:0] exp_q;
   } vec_t;

   logic       clk;
   logic       rst_a;
   logic       d_a;
   logic       q_a;
   logic       rst_b;
   logic [7:0] d_b;
   logic [7:0] q_b;

   int n_compared;
   int n_mismatched;

   vec_t vec_a [13];
   vec_t vec_b [13];

   d_ff dut_a (
      .CLK (clk),
      .RST (rst_a),
      .D   (d_a),
      .Q   (q_a)
   );

   d_ff #(
      .WIDTH       (8),
      .STAGES      (3),
      .RESET_VALUE (8'hA5)
   ) dut_b (
      .CLK (clk),
      .RST (rst_b),
      .D   (d_b),
      .Q   (q_b)
   );

   // Free-running clock: rising edges at 10, 30, 50, ... ns.
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   // Inputs change on the falling edge, well away from the sampling edge.
   task automatic applyStimulus(input bit sel_b, input logic r, input logic [7:0] dv);
      @(negedge clk);
      if (sel_b) begin
         rst_b = r;
         d_b   = dv;
      end else begin
         rst_a = r;
         d_a   = dv[0];
      end
   endtask

   task automatic checkOutput(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      rst_a = 1'b0;
      d_a   = 1'b0;
      rst_b = 1'b0;
      d_b   = 8'h00;

      // Default 1-bit DFF: reset, release with D=1, hold, D=0, sync reset.
      vec_a[0]  = '{rst: 1'b0, d: 8'h00, exp_q: 8'h00};
      vec_a[1]  = '{rst: 1'b0, d: 8'h00, exp_q: 8'h00};
      vec_a[2]  = '{rst: 1'b0, d: 8'h00, exp_q: 8'h00};
      vec_a[3]  = '{rst: 1'b0, d: 8'h00, exp_q: 8'h00};
      vec_a[4]  = '{rst: 1'b1, d: 8'h01, exp_q: 8'h01};
      vec_a[5]  = '{rst: 1'b1, d: 8'h01, exp_q: 8'h01};
      vec_a[6]  = '{rst: 1'b1, d: 8'h01, exp_q: 8'h01};
      vec_a[7]  = '{rst: 1'b1, d: 8'h01, exp_q: 8'h01};
      vec_a[8]  = '{rst: 1'b1, d: 8'h00, exp_q: 8'h00};
      vec_a[9]  = '{rst: 1'b1, d: 8'h01, exp_q: 8'h01};
      vec_a[10] = '{rst: 1'b0, d: 8'h01, exp_q: 8'h00};
      vec_a[11] = '{rst: 1'b1, d: 8'h01, exp_q: 8'h01};
      vec_a[12] = '{rst: 1'b1, d: 8'h00, exp_q: 8'h00};

      // 8-bit, 3-stage, reset value A5: reset ignores D, release shows A5
      // for two more edges, then the stream; a one-edge reset flushes it.
      vec_b[0]  = '{rst: 1'b0, d: 8'h00, exp_q: 8'hA5};
      vec_b[1]  = '{rst: 1'b0, d: 8'hFF, exp_q: 8'hA5};
      vec_b[2]  = '{rst: 1'b1, d: 8'h01, exp_q: 8'hA5};
      vec_b[3]  = '{rst: 1'b1, d: 8'h02, exp_q: 8'hA5};
      vec_b[4]  = '{rst: 1'b1, d: 8'h03, exp_q: 8'h01};
      vec_b[5]  = '{rst: 1'b1, d: 8'h04, exp_q: 8'h02};
      vec_b[6]  = '{rst: 1'b1, d: 8'h05, exp_q: 8'h03};
      vec_b[7]  = '{rst: 1'b1, d: 8'h06, exp_q: 8'h04};
      vec_b[8]  = '{rst: 1'b0, d: 8'h07, exp_q: 8'hA5};
      vec_b[9]  = '{rst: 1'b1, d: 8'h08, exp_q: 8'hA5};
      vec_b[10] = '{rst: 1'b1, d: 8'h09, exp_q: 8'hA5};
      vec_b[11] = '{rst: 1'b1, d: 8'h0A, exp_q: 8'h08};
      vec_b[12] = '{rst: 1'b1, d: 8'h0B, exp_q: 8'h09};

      $display("[TB] starting d_ff checks");

      for (int i = 0; i < 13; i++) begin
         applyStimulus(1'b0, vec_a[i].rst, vec_a[i].d);
         @(posedge clk);
         #1;
         checkOutput($sformatf("table_a[%0d]", i), {7'b0, q_a}, vec_a[i].exp_q);
      end

      // D glitches 0->1->0 between edges: Q holds 0 mid-cycle and after.
      applyStimulus(1'b0, 1'b1, 8'h00);
      @(posedge clk);
      #1;
      checkOutput("a_pre_glitch", {7'b0, q_a}, 8'h00);
      #3 d_a = 1'b1;
      #3 checkOutput("a_d_glitch_mid", {7'b0, q_a}, 8'h00);
      #3 d_a = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("a_d_glitch_after", {7'b0, q_a}, 8'h00);

      // Short RST low pulse between edges with D=1: Q must not clear.
      applyStimulus(1'b0, 1'b1, 8'h01);
      @(posedge clk);
      #1;
      checkOutput("a_pre_rst_pulse", {7'b0, q_a}, 8'h01);
      #3 rst_a = 1'b0;
      #3 checkOutput("a_rst_pulse_mid", {7'b0, q_a}, 8'h01);
      #3 rst_a = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("a_rst_pulse_after", {7'b0, q_a}, 8'h01);

      for (int i = 0; i < 13; i++) begin
         applyStimulus(1'b1, vec_b[i].rst, vec_b[i].d);
         @(posedge clk);
         #1;
         checkOutput($sformatf("table_b[%0d]", i), q_b, vec_b[i].exp_q);
      end

      // Pipeline holds 0B,0A,09. A short RST pulse between edges must not
      // flush it, and D changing mid-cycle must not reach Q early.
      #3 rst_b = 1'b0;
      d_b = 8'h0C;
      #3 checkOutput("b_rst_pulse_mid", q_b, 8'h09);
      #3 rst_b = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("b_rst_pulse_after", q_b, 8'h0A);
      @(posedge clk);
      #1;
      checkOutput("b_shift_0b", q_b, 8'h0B);
      @(posedge clk);
      #1;
      checkOutput("b_shift_0c", q_b, 8'h0C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule : tb_d_ff
